// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and default widths.
// Used by both the transmit and receive paths.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH     = 8;
    localparam int unsigned UART_PRESCALE_WIDTH = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side request bundle and serial-side outputs of the UART transmitter.
// The master is the byte source; the slave is the transmitter.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) ();

    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      par_en;
    logic                      par_typ;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      tx_out;
    logic                      busy;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        output prescale,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        input  prescale,
        output tx_out,
        output busy
    );

endinterface

// File: rtl/uart_tx_baud_counter.sv
// Bit-period timer (counts 1..P, P = prescale or 1 when prescale is 0) and data bit index.
// Emits a one-cycle tick on the last cycle of every bit period.
module uart_tx_baud_counter #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6,
    parameter int unsigned IDX_WIDTH      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_data_phase,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_bit_tick,
    output logic [IDX_WIDTH-1:0]      o_bit_idx,
    output logic                      o_last_bit
);

    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [IDX_WIDTH-1:0]      r_idx;
    logic [PRESCALE_WIDTH-1:0] w_period;
    logic                      w_tick;

    assign w_period = (i_prescale == '0) ? PRESCALE_WIDTH'(1) : i_prescale;
    assign w_tick   = i_enable && (r_cnt >= w_period);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= PRESCALE_WIDTH'(1);
            r_idx <= '0;
        end else begin
            if (!i_enable || w_tick) begin
                r_cnt <= PRESCALE_WIDTH'(1);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Index only advances inside the data phase and is cleared everywhere else.
            if (!i_data_phase) begin
                r_idx <= '0;
            end else if (w_tick) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_bit_tick = w_tick;
    assign o_bit_idx  = r_idx;
    assign o_last_bit = (r_idx == IDX_WIDTH'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB-first, optional parity, stop bit.
// All frame settings are latched on acceptance; tx_out and busy are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
    input  logic     CLK,
    input  logic     RST,
    uart_tx_if.slave bus
);

    localparam int unsigned IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e                 r_state;
    tx_state_e                 w_state_d;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_tx_out;
    logic                      w_tx_out_d;
    logic                      r_busy;
    logic                      w_accept;
    logic                      w_cnt_en;
    logic                      w_data_phase;
    logic                      w_bit_tick;
    logic                      w_last_bit;
    logic [IDX_WIDTH-1:0]      w_bit_idx;
    logic [IDX_WIDTH-1:0]      w_next_idx;

    assign w_accept     = (r_state == IDLE) && bus.data_valid;
    assign w_cnt_en     = (r_state != IDLE);
    assign w_data_phase = (r_state == DATA);
    assign w_next_idx   = w_bit_idx + 1'b1;

    uart_tx_baud_counter #(
        .DATA_WIDTH     (DATA_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .IDX_WIDTH      (IDX_WIDTH)
    ) u_baud (
        .i_clk        (CLK),
        .i_rst_n      (RST),
        .i_enable     (w_cnt_en),
        .i_data_phase (w_data_phase),
        .i_prescale   (r_prescale),
        .o_bit_tick   (w_bit_tick),
        .o_bit_idx    (w_bit_idx),
        .o_last_bit   (w_last_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= PAR_EVEN;
            r_prescale <= '0;
        end else if (w_accept) begin
            r_data     <= bus.p_data;
            r_par_en   <= bus.par_en;
            r_par_typ  <= bus.par_typ;
            r_prescale <= bus.prescale;
        end
    end

    // Next line level is computed for the state being entered, so tx_out is a clean register.
    always_comb begin
        w_state_d  = r_state;
        w_tx_out_d = r_tx_out;
        unique case (r_state)
            IDLE: begin
                w_tx_out_d = 1'b1;
                if (w_accept) begin
                    w_state_d  = START;
                    w_tx_out_d = 1'b0;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_d  = DATA;
                    w_tx_out_d = r_data[0];
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (!w_last_bit) begin
                        w_tx_out_d = r_data[w_next_idx];
                    end else if (r_par_en) begin
                        w_state_d  = PARITY;
                        w_tx_out_d = (^r_data) ^ r_par_typ;
                    end else begin
                        w_state_d  = STOP;
                        w_tx_out_d = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_state_d  = STOP;
                    w_tx_out_d = 1'b1;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    w_state_d  = IDLE;
                    w_tx_out_d = 1'b1;
                end
            end
            default: begin
                w_state_d  = IDLE;
                w_tx_out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_tx_out <= w_tx_out_d;
            r_busy   <= (w_state_d != IDLE);
        end
    end

    assign bus.tx_out = r_tx_out;
    assign bus.busy   = r_busy;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the oversampled UART receive path. It accepts a parallel byte with a valid strobe and serialises it as start bit, 8 data bits LSB-first, optional parity bit, and stop bit. Bit timing is measured in CLK cycles per bit (`prescale`), so TX and RX share one baud configuration. It sits between the system controller's TX FIFO/read logic and the `tx_out` pad.

## Interface

- `DATA_WIDTH`, default 8: payload bits per frame.
- `PRESCALE_WIDTH`, default 6: width of the `prescale` port.
- `CLK` (in, 1): single clock, rising edge.
- `RST` (in, 1): asynchronous, active-low reset.
- `p_data` (in, DATA_WIDTH): byte to transmit. Sampled on acceptance.
- `data_valid` (in, 1): transmit request. Accepted only in IDLE.
- `par_en` (in, 1): 1 means a parity bit is inserted. Sampled on acceptance.
- `par_typ` (in, 1): 0 means even parity, 1 means odd parity. Sampled on acceptance.
- `prescale` (in, PRESCALE_WIDTH): CLK cycles per bit. Sampled on acceptance. A value of 0 is treated as 1.
- `tx_out` (out, 1): serial line, registered, idles high.
- `busy` (out, 1): frame in progress, registered.

## Operation

- **FSM states**: IDLE, START, DATA, PARITY, STOP.
- **IDLE**: `tx_out` is 1 and `busy` is 0. If `data_valid` is 1 at a rising edge:
  - latch `p_data`, `par_en`, `par_typ` and `prescale`;
  - go to START.
- **START**: `tx_out` is 0 for one bit period, then go to DATA.
- **DATA**: `tx_out` is `data_reg[bit_idx]`, with `bit_idx` counting 0..DATA_WIDTH-1. Each bit lasts one bit period. After the last bit, go to PARITY if the latched `par_en` is 1, otherwise go to STOP.
- **PARITY**: `tx_out` is the XOR-reduce of `data_reg`, XORed with the latched `par_typ`. It lasts one bit period, then go to STOP.
- **STOP**: `tx_out` is 1 for one bit period, then go to IDLE.
- **Bit period**: an edge counter counts 1..P, where P is the latched prescale (or 1 if it is 0). When the counter equals P, a bit tick is produced and the counter reloads to 1. The counter is held at 1 in IDLE.
- **Handshake**:
  - `data_valid` is ignored while `busy` is 1. There is no queuing and no error flag.
  - The source must hold `p_data` stable only in the acceptance cycle.
- **Input changes**: changes to `prescale`, `par_en` or `par_typ` mid-frame have no effect on the current frame.
- **Parity input**: parity is computed on the latched data, never on live `p_data`.
- **Reset**: assertion forces, immediately and asynchronously:
  - `tx_out` to 1 and `busy` to 0;
  - the FSM to IDLE;
  - the counters to 1 and 0;
  - `data_reg` to 0.
  
  A frame in flight is abandoned with no partial stop bit. The line returns to idle-high.

## Timing

- **Reset values**: `tx_out` is 1 and `busy` is 0.
- **Acceptance**: `data_valid` is sampled at edge N. `tx_out` falls to 0 and `busy` rises after edge N, so they are first seen in cycle N+1.
- **Frame length**: (1 + DATA_WIDTH + par_en + 1) × P cycles. With P = 16 and parity on, that is 176 cycles.
- **Line transitions**: `tx_out` changes only on bit-tick edges, so it is glitch-free and registered.
- **Busy release**: `busy` falls on the same edge at which STOP completes, so `tx_out` stays 1.
- **Back-to-back frames**: the earliest next acceptance is at the first IDLE edge. This gives a minimum of one idle-high cycle between frames.
- **`data_valid` during STOP**: a pulse in STOP's last cycle is ignored. Sources must wait for `busy` to be 0.

## Structure

- **Shared package `uart_pkg`**:
  - FSM state enum: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, in 3-bit binary encoding;
  - parity constants `PAR_EVEN`=0 and `PAR_ODD`=1;
  - default widths DATA_WIDTH and PRESCALE_WIDTH.
  
  The receiver uses the same package.
- **Sub-module `uart_tx_baud_counter`**:
  - contains the edge counter 1..P and the bit index;
  - inputs: `enable` and the latched prescale;
  - outputs: `bit_tick` and `bit_idx`.
  
  The FSM, data register, parity and output register stay in `uart_tx`.

## Test plan

- **Reset values**: reset, then release with no `data_valid`. `tx_out` is 1 and `busy` is 0 for 100 cycles.
- **Even parity**: P=8, `p_data`=0xA5, `par_en`=1, `par_typ`=0. `tx_out` shows 0,1,0,1,0,0,1,0,1,0,1, each bit for 8 cycles. `busy` is high for exactly 88 cycles.
- **Odd parity, no parity, prescale edge cases**:
  - P=8, 0xA5, `par_typ`=1: the parity bit is 1.
  - P=16, 0x00, `par_en`=0: 10 bits, 160 busy cycles.
  - `prescale`=0 behaves as P=1: 11 cycles.
- **Ignored inputs while busy**: during a P=8, 0x3C frame, pulse `data_valid` with 0xFF and change `prescale` to 16. The frame is unchanged. After `busy` falls, nothing further is sent.
- **Back-to-back frames**: drive `data_valid` at the first IDLE cycle, 0x81 then 0x7E. Exactly one idle-high cycle separates the two stop→start boundaries, and both frames decode correctly.
- **Reset mid-frame**: assert RST in the middle of data bit 3. `tx_out` is 1 and `busy` is 0 asynchronously, before the next edge. After release, a new 0x55 frame transmits cleanly.
